// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: multi-byte SPI transaction controller above a single-byte
// SPI engine. Round-robin arbitration between two requesters, per-requester
// active-low chip select, 1-4 byte bursts, CS setup/hold/gap timing and a
// per-byte watchdog.
module spi_txn_sequencer #(
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned CS_GAP   = 8,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [1:0]  req0_len,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_len,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  cs_n,
    output logic        spi_start,
    output logic [7:0]  spi_data_in,
    input  logic        spi_busy,
    input  logic        spi_new_data,
    input  logic [7:0]  spi_data_out
);

    localparam int unsigned MAX_AB = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned MAX_CD = (CS_GAP > TIMEOUT) ? CS_GAP : TIMEOUT;
    localparam int unsigned MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW     = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT,
        HOLD,
        GAP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic          cur_id;
    logic [1:0]    byte_cnt;
    logic [31:0]   tx_sr;
    logic [31:0]   rx_sr;
    logic          err_q;
    logic          last_grant;
    logic          grant;
    logic          accept;

    assign cnt_zero = (cnt == '0);

    // Next-state logic, arbitration and combinational engine/CS outputs.
    always_comb begin
        state_d     = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        spi_start   = 1'b0;
        spi_data_in = '0;
        cs_n        = '1;
        accept      = 1'b0;
        grant       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    accept     = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                cs_n = cur_id ? 2'b01 : 2'b10;
                if (cnt_zero) state_d = START;
            end
            START: begin
                cs_n = cur_id ? 2'b01 : 2'b10;
                if (!spi_busy) begin
                    spi_start   = 1'b1;
                    spi_data_in = tx_sr[31:24];
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                cs_n = cur_id ? 2'b01 : 2'b10;
                if (spi_new_data) state_d = (byte_cnt == 2'd0) ? HOLD : START;
                else if (cnt_zero) state_d = HOLD;
            end
            HOLD: begin
                cs_n = cur_id ? 2'b01 : 2'b10;
                if (cnt_zero) state_d = GAP;
            end
            GAP: begin
                if (cnt_zero) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs take their idle values for every cycle rst is high.
        if (rst) begin
            req0_ready  = 1'b0;
            req1_ready  = 1'b0;
            accept      = 1'b0;
            spi_start   = 1'b0;
            spi_data_in = '0;
            cs_n        = '1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Datapath: request latch, shift registers, shared timing counter, response.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            cur_id      <= 1'b0;
            byte_cnt    <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            err_q       <= 1'b0;
            last_grant  <= 1'b1;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_id     <= grant;
                        last_grant <= grant;
                        byte_cnt   <= grant ? req1_len : req0_len;
                        tx_sr      <= grant ? req1_wdata : req0_wdata;
                        rx_sr      <= '0;
                        err_q      <= 1'b0;
                        cnt        <= CW'(CS_SETUP - 1);
                    end
                end
                SETUP: begin
                    if (!cnt_zero) cnt <= cnt - 1'b1;
                end
                START: begin
                    if (!spi_busy) begin
                        tx_sr <= {tx_sr[23:0], 8'h00};
                        cnt   <= CW'(TIMEOUT - 1);
                    end
                end
                WAIT: begin
                    // A done pulse on the final count still wins over the watchdog.
                    if (spi_new_data) begin
                        rx_sr <= {rx_sr[23:0], spi_data_out};
                        if (byte_cnt == 2'd0) cnt <= CW'(CS_HOLD - 1);
                        else byte_cnt <= byte_cnt - 2'd1;
                    end else if (cnt_zero) begin
                        err_q <= 1'b1;
                        cnt   <= CW'(CS_HOLD - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        resp0_valid <= ~cur_id;
                        resp1_valid <= cur_id;
                        resp_rdata  <= rx_sr;
                        resp_err    <= err_q;
                        cnt         <= CW'(CS_GAP - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (!cnt_zero) cnt <= cnt - 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
